fifo2_sched_ctrl: RTL and testbench

FIFO2_SCHED_CTRL -- requirements
Module: fifo2_sched_ctrl

---
 rtl/fifo2_sched_ctrl.sv | 113 +++++++++++
 tb/tb_fifo2_sched_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo2_sched_ctrl.sv
// Write/read scheduler for a 3-in/2-out pixel FIFO: round-robin arbitration,
// occupancy tracking, registered pair output with end-of-row marking.
module fifo2_sched_ctrl #(
  parameter int DW         = 8,
  parameter int FIFO_DEPTH = 64,
  parameter int LINE_PAIRS = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [1:0]                 in_cnt,
  input  logic [DW*3-1:0]            in_data,
  output logic                       in_ready,
  output logic                       fifo_wr_en1,
  output logic                       fifo_wr_en2,
  output logic [DW*3-1:0]            fifo_wr_data,
  output logic                       fifo_rd_en,
  input  logic [DW*2-1:0]            fifo_rd_data,
  output logic                       out_valid,
  output logic [DW*2-1:0]            out_data,
  output logic                       out_last,
  input  logic                       out_ready,
  output logic [$clog2(FIFO_DEPTH):0] occ,
  output logic                       err_cnt0
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = (LINE_PAIRS > 1) ? $clog2(LINE_PAIRS) : 1;
  localparam logic [AW:0]   OCC_WR_MAX = (AW+1)'(FIFO_DEPTH - 3);
  localparam logic [PW-1:0] PAIR_LAST  = PW'(LINE_PAIRS - 1);
  localparam logic GRANT_WR = 1'b1;
  localparam logic GRANT_RD = 1'b0;

  logic [AW:0]     occ_q, occ_d;
  logic            out_valid_q, out_valid_d;
  logic [DW*2-1:0] out_data_q, out_data_d;
  logic            out_last_q, out_last_d;
  logic [PW-1:0]   pair_q, pair_d;
  logic            last_grant_q, last_grant_d;
  logic            err_q, err_d;

  logic wr_elig, rd_elig, wr_req, in_ready_w, wr_grant, rd_grant;

  always_comb begin
    wr_elig    = (occ_q <= OCC_WR_MAX);
    rd_elig    = (occ_q >= (AW+1)'(2)) && (!out_valid_q || out_ready);
    wr_req     = in_valid && (in_cnt != 2'd0);
    // zero-count beats are always swallowed so they never stall upstream
    in_ready_w = rst_n && ((in_cnt == 2'd0) ||
                           (wr_elig && !(rd_elig && last_grant_q == GRANT_WR)));
    wr_grant   = wr_req && in_ready_w;
    rd_grant   = rst_n && rd_elig && !wr_grant;
  end

  always_comb begin
    occ_d        = occ_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    pair_d       = pair_q;
    last_grant_d = last_grant_q;
    err_d        = err_q | (in_valid && (in_cnt == 2'd0));

    if (wr_grant) begin
      occ_d        = occ_q + (AW+1)'(in_cnt);
      last_grant_d = GRANT_WR;
    end else if (rd_grant) begin
      occ_d        = occ_q - (AW+1)'(2);
      last_grant_d = GRANT_RD;
    end

    if (rd_grant) begin
      out_valid_d = 1'b1;
      out_data_d  = fifo_rd_data;
      out_last_d  = (pair_q == PAIR_LAST);
      pair_d      = (pair_q == PAIR_LAST) ? '0 : pair_q + PW'(1);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q        <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      pair_q       <= '0;
      last_grant_q <= GRANT_RD;
      err_q        <= 1'b0;
    end else begin
      occ_q        <= occ_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      pair_q       <= pair_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
    end
  end

  assign in_ready     = in_ready_w;
  assign fifo_wr_en1  = wr_grant & in_cnt[1];
  assign fifo_wr_en2  = wr_grant & in_cnt[0];
  assign fifo_wr_data = in_data;
  assign fifo_rd_en   = rd_grant;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_last     = out_last_q;
  assign occ          = occ_q;
  assign err_cnt0     = err_q;

endmodule

// File: tb/tb_fifo2_sched_ctrl.sv
// Bench for fifo2_sched_ctrl: behavioural FIFO environment, queue-based
// reference model checked every cycle, directed scenarios plus random traffic.
module tb_fifo2_sched_ctrl;
  localparam int DW = 8;
  localparam int DEPTH = 64;
  localparam int LP = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  in_cnt = 2'd1;
  logic [23:0] in_data = '0;
  logic        in_ready;
  logic        fifo_wr_en1, fifo_wr_en2;
  logic [23:0] fifo_wr_data;
  logic        fifo_rd_en;
  logic [15:0] fifo_rd_data;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_last;
  logic        out_ready = 1'b0;
  logic [6:0]  occ;
  logic        err_cnt0;

  fifo2_sched_ctrl #(.DW(DW), .FIFO_DEPTH(DEPTH), .LINE_PAIRS(LP)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_cnt(in_cnt),
    .in_data(in_data), .in_ready(in_ready), .fifo_wr_en1(fifo_wr_en1),
    .fifo_wr_en2(fifo_wr_en2), .fifo_wr_data(fifo_wr_data),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .occ(occ), .err_cnt0(err_cnt0));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: bound expired at %0t", nm, $time);
  endtask

  // FIFO environment driven by the DUT strobes
  logic [7:0]  mem [0:255];
  logic [7:0]  wp = '0, rp = '0;
  logic [1:0]  pend_wr = '0;
  logic [23:0] pend_data = '0;
  logic        pend_rd = 1'b0;

  assign fifo_rd_data = {mem[rp], mem[rp + 8'd1]};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      case (pend_wr)
        2'b11: begin
          mem[wp] <= pend_data[23:16]; mem[wp + 8'd1] <= pend_data[15:8];
          mem[wp + 8'd2] <= pend_data[7:0]; wp <= wp + 8'd3;
        end
        2'b10: begin
          mem[wp] <= pend_data[15:8]; mem[wp + 8'd1] <= pend_data[7:0];
          wp <= wp + 8'd2;
        end
        2'b01: begin
          mem[wp] <= pend_data[23:16]; wp <= wp + 8'd1;
        end
        default: ;
      endcase
      if (pend_rd) rp <= rp + 8'd2;
    end
  end

  // Reference model: pixel queue holds the words the FIFO must contain
  logic [7:0]  pq [$];
  logic [15:0] cap [$];
  bit          capl [$];
  bit          m_valid = 0, m_last = 0, m_lg_wr = 0, m_err = 0;
  logic [15:0] m_data = '0;
  int          m_pairs = 0;

  always @(negedge clk) begin
    int space, win;
    bit wr_ok, rd_ok, wr_req, e_rdy;
    logic [1:0] e_wr;
    logic [7:0] p0, p1;
    if (!rst_n) begin
      chk("rst_occ", occ, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_err_cnt0", err_cnt0, 0);
      chk("rst_strobes", {fifo_wr_en1, fifo_wr_en2, fifo_rd_en}, 0);
      pq.delete();
      m_valid = 0; m_last = 0; m_lg_wr = 0; m_err = 0; m_data = '0; m_pairs = 0;
      pend_wr = '0; pend_rd = 1'b0;
    end else begin
      chk("occ", occ, pq.size());
      chk("out_valid", out_valid, m_valid);
      if (m_valid) begin
        chk("out_data", out_data, m_data);
        chk("out_last", out_last, m_last);
      end
      chk("err_cnt0", err_cnt0, m_err);

      space  = DEPTH - pq.size();
      wr_ok  = space >= 3;
      rd_ok  = (pq.size() >= 2) && (!m_valid || out_ready);
      wr_req = in_valid && (in_cnt != 0);
      if (wr_req && wr_ok && rd_ok) win = m_lg_wr ? 2 : 1;
      else if (wr_req && wr_ok)     win = 1;
      else if (rd_ok)               win = 2;
      else                          win = 0;
      e_rdy = (in_cnt == 0) || (wr_ok && !(rd_ok && m_lg_wr));
      e_wr = 2'b00;
      if (win == 1) begin
        case (in_cnt)
          2'd3: e_wr = 2'b11;
          2'd2: e_wr = 2'b10;
          2'd1: e_wr = 2'b01;
          default: e_wr = 2'b00;
        endcase
      end
      chk("in_ready", in_ready, e_rdy);
      chk("wr_enc", {fifo_wr_en1, fifo_wr_en2}, e_wr);
      chk("rd_en", fifo_rd_en, win == 2);

      if (out_valid && out_ready) begin
        cap.push_back(out_data);
        capl.push_back(out_last);
      end
      pend_wr   = {fifo_wr_en1, fifo_wr_en2};
      pend_data = fifo_wr_data;
      pend_rd   = fifo_rd_en;

      if (in_valid && in_cnt == 0) m_err = 1;
      if (win == 1) begin
        if (in_cnt == 3) begin
          pq.push_back(in_data[23:16]); pq.push_back(in_data[15:8]); pq.push_back(in_data[7:0]);
        end else if (in_cnt == 2) begin
          pq.push_back(in_data[15:8]); pq.push_back(in_data[7:0]);
        end else begin
          pq.push_back(in_data[23:16]);
        end
        m_lg_wr = 1;
      end else if (win == 2) begin
        p0 = pq.pop_front();
        p1 = pq.pop_front();
        m_data = {p0, p1};
        m_last = (m_pairs % LP) == (LP - 1);
        m_pairs++;
        m_lg_wr = 0;
      end
      if (win == 2) m_valid = 1;
      else if (out_ready) m_valid = 0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 0;
    rst_n = 0;
    repeat (2) cyc();
    rst_n = 1;
    cap.delete();
    capl.delete();
  endtask

  task automatic send(input logic [1:0] c, input logic [23:0] d);
    int n;
    bit acc;
    n = 0; acc = 0;
    in_valid = 1; in_cnt = c; in_data = d;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      cyc();
      n++;
    end
    in_valid = 0;
    if (!acc) fail_now("send_timeout");
  endtask

  task automatic wait_drain(input int max);
    int n;
    bit done;
    n = 0; done = 0;
    while (!done && n < max) begin
      @(negedge clk);
      done = (occ == 0) && !out_valid;
      cyc();
      n++;
    end
    if (!done) fail_now("drain_timeout");
  endtask

  initial begin
    bit rd_seen;
    logic [9:0]  lastv;
    logic [19:0] wr_pat;
    int overlap, rdn;

    // reset state and 3-pixel beats ABC / DEF
    do_reset();
    @(negedge clk);
    chk("lit_reset_occ", occ, 0);
    chk("lit_reset_valid", out_valid, 0);
    chk("lit_reset_in_ready", in_ready, 1);
    cyc();
    out_ready = 1;
    in_valid = 1; in_cnt = 3; in_data = 24'hA1B2C3;
    @(negedge clk);
    chk("lit_wr_enc_3", {fifo_wr_en1, fifo_wr_en2}, 2'b11);
    cyc();
    in_data = 24'hD4E5F6;
    @(negedge clk);
    chk("lit_occ_after_abc", occ, 3);
    chk("lit_rd_beats_wr_tie", {in_ready, fifo_rd_en}, 2'b01);
    cyc();
    send(3, 24'hD4E5F6);
    wait_drain(30);
    chk("lit_pairs_count", cap.size(), 3);
    if (cap.size() == 3) begin
      chk("lit_pair_ab", cap[0], 16'hA1B2);
      chk("lit_pair_cd", cap[1], 16'hC3D4);
      chk("lit_pair_ef", cap[2], 16'hE5F6);
    end

    // odd occupancy holds the lone word
    do_reset();
    out_ready = 1;
    send(1, 24'h110000);
    rd_seen = 0;
    repeat (5) begin
      @(negedge clk);
      rd_seen |= fifo_rd_en;
      cyc();
    end
    @(negedge clk);
    chk("lit_odd_occ", occ, 1);
    chk("lit_odd_no_read", rd_seen, 0);
    cyc();
    send(1, 24'h220000);
    wait_drain(20);
    chk("lit_odd_pair_count", cap.size(), 1);
    if (cap.size() == 1) chk("lit_odd_pair", cap[0], 16'h1122);

    // zero-count beat, then reset at occ 5
    do_reset();
    out_ready = 0;
    in_valid = 1; in_cnt = 0; in_data = 24'hFFFFFF;
    @(negedge clk);
    chk("lit_cnt0_ready_nowr", {in_ready, fifo_wr_en1, fifo_wr_en2}, 3'b100);
    cyc();
    in_valid = 0;
    send(3, 24'h010203);
    send(2, 24'h000405);
    send(2, 24'h000607);
    @(negedge clk);
    chk("lit_occ5", occ, 5);
    chk("lit_err_sticky", err_cnt0, 1);
    #2 rst_n = 0;
    #1;
    chk("lit_midrst_state", {occ, out_valid, err_cnt0}, 0);
    cyc();
    cyc();
    rst_n = 1;

    // out_last on every LP-th pair
    do_reset();
    out_ready = 1;
    in_cnt = 2;
    for (int i = 0; i < 100 && cap.size() < 10; i++) begin
      in_valid = 1; in_data = $urandom;
      cyc();
    end
    in_valid = 0;
    lastv = '0;
    for (int i = 0; i < 10 && i < capl.size(); i++) lastv[i] = capl[i];
    chk("lit_out_last_pattern", lastv, 10'b0010001000);
    wait_drain(20);

    // continuous 2-pixel beats alternate write/read
    do_reset();
    out_ready = 1;
    in_valid = 1; in_cnt = 2;
    wr_pat = '0; overlap = 0; rdn = 0;
    for (int i = 0; i < 20; i++) begin
      in_data = $urandom;
      @(negedge clk);
      wr_pat[i] = fifo_wr_en1 | fifo_wr_en2;
      if (fifo_rd_en) rdn++;
      if (fifo_rd_en && (fifo_wr_en1 | fifo_wr_en2)) overlap++;
      cyc();
    end
    in_valid = 0;
    chk("lit_alt_wr_pattern", wr_pat, 20'h55555);
    chk("lit_alt_reads", rdn, 10);
    chk("lit_alt_overlap", overlap, 0);
    wait_drain(20);

    // fill with output stalled, then drain
    do_reset();
    out_ready = 0;
    in_valid = 1; in_cnt = 3;
    for (int i = 0; i < 40; i++) begin
      in_data = $urandom;
      cyc();
    end
    @(negedge clk);
    chk("lit_full_occ", occ, 64);
    chk("lit_full_not_ready", in_ready, 0);
    cyc();
    in_valid = 0;
    out_ready = 1;
    wait_drain(100);
    chk("lit_full_pairs", cap.size(), 33);

    // random traffic
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) begin
        in_valid = 0;
        rst_n = 0;
        cyc();
        cyc();
        rst_n = 1;
      end
      in_valid = ($urandom_range(0, 99) < 75);
      in_cnt = ($urandom_range(0, 29) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
      in_data = $urandom;
      if ((i % 500) < 150) out_ready = ($urandom_range(0, 99) < 20);
      else                 out_ready = ($urandom_range(0, 99) < 85);
      cyc();
    end
    in_valid = 0;
    out_ready = 1;
    wait_drain(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
